dmem_bridge: RTL

Data-memory bridge placed directly downstream of the single-cycle datapath. It takes the datapath's `aluout` address, its `writedata`, and the control unit's `memread`/`memwrite` strobes. It runs each access as a request/acknowledge transaction on a variable-latency memory port and returns `readdata` to the datapath's result mux. Until the access completes it holds the core with `stall`, which gates the PC register and register-file write enable.

---
 rtl/dmem_bridge.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dmem_bridge.sv
// Data-memory bridge: one CPU load/store -> req/ack memory transaction; 3+ cycle latency, stall held until ack or TIMEOUT.
// Optional DMEM_BRIDGE_WBUF_EN adds a single-entry posted write buffer (stores retire unstalled, drained in DRAIN).
module dmem_bridge #(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memread,
  input  logic          memwrite,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   readdata,
  output logic          stall,
  output logic          dmem_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

`ifdef DMEM_BRIDGE_WBUF_EN
  typedef enum logic [1:0] {IDLE, REQ, DONE, DRAIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
`endif

  state_t          state_q, state_d;
  logic [AW-3:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic            we_q;
  logic            err_q;
  logic [CW-1:0]   cnt_q;
  logic            busy;
  logic            capture;
  logic            timeout_hit;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];

  // busy covers every state that owns the memory port
`ifdef DMEM_BRIDGE_WBUF_EN
  assign busy = (state_q == REQ) || (state_q == DRAIN);
`else
  assign busy = (state_q == REQ);
`endif

  assign timeout_hit = busy && !mem_ack && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    mem_req = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (memread || memwrite) begin
          capture = 1'b1;
`ifdef DMEM_BRIDGE_WBUF_EN
          if (memwrite) begin
            state_d = DRAIN;
          end else begin
            stall   = 1'b1;
            state_d = REQ;
          end
`else
          stall   = 1'b1;
          state_d = REQ;
`endif
        end
      end
      REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ack || timeout_hit) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
`ifdef DMEM_BRIDGE_WBUF_EN
      DRAIN: begin
        mem_req = 1'b1;
        // any new access waits for the posted store, preserving RAW order
        stall   = memread || memwrite;
        if (mem_ack || timeout_hit) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        addr_q  <= addr[AW-1:2];
        wdata_q <= wdata;
        we_q    <= memwrite;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (!busy || mem_ack || timeout_hit) begin
        cnt_q <= '0;
      end else if (cnt_q != {CW{1'b1}}) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (busy && mem_ack && !we_q) begin
        rdata_q <= mem_rdata;
      end else if (timeout_hit) begin
        rdata_q <= 32'hDEAD_BEEF;
      end
      if (timeout_hit) err_q <= 1'b1;
    end
  end

  assign readdata  = rdata_q;
  assign dmem_err  = err_q;
  assign mem_we    = we_q;
  assign mem_addr  = {addr_q, 2'b00};
  assign mem_wdata = wdata_q;

endmodule
